// File: rtl/wb_arbiter2_if.sv
// Wishbone B4 bus bundle (classic + registered burst) shared by the arbiter
// master-facing and slave-facing sides.
//   addr/dat_w/sel : address, write data, byte selects (master -> slave)
//   cyc/stb/we     : cycle, strobe, write enable       (master -> slave)
//   cti/bte        : cycle type, burst type extension  (master -> slave)
//   dat_r/ack/err  : read data, acknowledge, error     (slave -> master)
// Modport "master" is the side that starts cycles; "slave" answers them.
interface wb_arbiter2_if;
  logic [31:0] addr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output addr, dat_w, sel, cyc, stb, we, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  addr, dat_w, sel, cyc, stb, we, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone arbiter. m0 is the core instruction port,
// m1 the data port; both share one slave. A grant is held for the whole bus
// cycle (cyc high), so bursts and read-modify-write sequences are never split.
// A watchdog raises a one-cycle err to the granted master when the slave
// leaves a strobe unanswered for TIMEOUT cycles.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   m0  : instruction-port master bus (arbiter acts as its slave)
//   m1  : data-port master bus (arbiter acts as its slave)
//   s   : shared slave bus (arbiter acts as its master)
// Parameters:
//   PRIORITY : 0 = round-robin on ties, 1 = m1 always wins ties
//   TIMEOUT  : stalled strobe cycles before a watchdog err; 0 disables
module wb_arbiter2 #(
  parameter int unsigned PRIORITY = 0,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter2_if.slave  m0,
  wb_arbiter2_if.slave  m1,
  wb_arbiter2_if.master s
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  logic granted;
  logic stb_g;
  logic resp;
  logic wd_err;
  logic win1;

  assign granted = (state_q != IDLE);
  assign stb_g   = (state_q == GNT0) ? m0.stb :
                   (state_q == GNT1) ? m1.stb : 1'b0;
  assign resp    = s.ack | s.err;

  // Fires on the TIMEOUT-th consecutive unanswered strobe; a real ack/err in
  // the same cycle suppresses it.
  assign wd_err  = (TIMEOUT != 0) && stb_g && !resp &&
                   (wd_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      wd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    win1       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          win1 = (PRIORITY != 0) || !last_gnt_q;
        end else begin
          win1 = m1.cyc;
        end
        if (m0.cyc || m1.cyc) begin
          state_d    = win1 ? GNT1 : GNT0;
          last_gnt_d = win1;
        end
      end
      GNT0: begin
        // Release goes straight to the waiting master without an idle cycle.
        if (!m0.cyc) begin
          if (m1.cyc) begin
            state_d    = GNT1;
            last_gnt_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GNT1: begin
        if (!m1.cyc) begin
          if (m0.cyc) begin
            state_d    = GNT0;
            last_gnt_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wd_cnt_d = wd_cnt_q + CW'(1);
    if (TIMEOUT == 0 || !granted || (state_d != state_q) ||
        resp || !stb_g || wd_err) begin
      wd_cnt_d = '0;
    end
  end

  always_comb begin
    s.addr   = '0;
    s.dat_w  = '0;
    s.sel    = '0;
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.cti    = '0;
    s.bte    = '0;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;
    unique case (state_q)
      GNT0: begin
        s.addr  = m0.addr;
        s.dat_w = m0.dat_w;
        s.sel   = m0.sel;
        s.cyc   = m0.cyc;
        s.stb   = m0.stb;
        s.we    = m0.we;
        s.cti   = m0.cti;
        s.bte   = m0.bte;
        m0.ack  = s.ack;
        m0.err  = s.err | wd_err;
      end
      GNT1: begin
        s.addr  = m1.addr;
        s.dat_w = m1.dat_w;
        s.sel   = m1.sel;
        s.cyc   = m1.cyc;
        s.stb   = m1.stb;
        s.we    = m1.we;
        s.cti   = m1.cti;
        s.bte   = m1.bte;
        m1.ack  = s.ack;
        m1.err  = s.err | wd_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: three instances share one stimulus stream
//   a: PRIORITY=0 TIMEOUT=16, b: PRIORITY=1 TIMEOUT=16, c: PRIORITY=0 TIMEOUT=0
// and every cycle is compared against an ownership/stall-count reference model.
module tb_wb_arbiter2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Master drive word: {addr, dat_w, sel, cyc, stb, we, cti, bte}
  // bit 7 = cyc, bit 6 = stb
  logic [75:0] mdrv [2];
  // Slave drive word: {dat_r, ack, err}
  logic [33:0] sdrv;

  wb_arbiter2_if m0a(), m1a(), sa();
  wb_arbiter2_if m0b(), m1b(), sb();
  wb_arbiter2_if m0c(), m1c(), sc();

  assign {m0a.addr, m0a.dat_w, m0a.sel, m0a.cyc, m0a.stb, m0a.we, m0a.cti, m0a.bte} = mdrv[0];
  assign {m1a.addr, m1a.dat_w, m1a.sel, m1a.cyc, m1a.stb, m1a.we, m1a.cti, m1a.bte} = mdrv[1];
  assign {m0b.addr, m0b.dat_w, m0b.sel, m0b.cyc, m0b.stb, m0b.we, m0b.cti, m0b.bte} = mdrv[0];
  assign {m1b.addr, m1b.dat_w, m1b.sel, m1b.cyc, m1b.stb, m1b.we, m1b.cti, m1b.bte} = mdrv[1];
  assign {m0c.addr, m0c.dat_w, m0c.sel, m0c.cyc, m0c.stb, m0c.we, m0c.cti, m0c.bte} = mdrv[0];
  assign {m1c.addr, m1c.dat_w, m1c.sel, m1c.cyc, m1c.stb, m1c.we, m1c.cti, m1c.bte} = mdrv[1];
  assign {sa.dat_r, sa.ack, sa.err} = sdrv;
  assign {sb.dat_r, sb.ack, sb.err} = sdrv;
  assign {sc.dat_r, sc.ack, sc.err} = sdrv;

  wb_arbiter2 #(.PRIORITY(0), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .m0(m0a.slave), .m1(m1a.slave), .s(sa.master));
  wb_arbiter2 #(.PRIORITY(1), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .m0(m0b.slave), .m1(m1b.slave), .s(sb.master));
  wb_arbiter2 #(.PRIORITY(0), .TIMEOUT(0)) dut_c (
    .clk(clk), .rst(rst), .m0(m0c.slave), .m1(m1c.slave), .s(sc.master));

  logic [75:0] obus  [3];
  logic [3:0]  oresp [3];
  logic [63:0] odr   [3];

  assign obus[0]  = {sa.addr, sa.dat_w, sa.sel, sa.cyc, sa.stb, sa.we, sa.cti, sa.bte};
  assign obus[1]  = {sb.addr, sb.dat_w, sb.sel, sb.cyc, sb.stb, sb.we, sb.cti, sb.bte};
  assign obus[2]  = {sc.addr, sc.dat_w, sc.sel, sc.cyc, sc.stb, sc.we, sc.cti, sc.bte};
  assign oresp[0] = {m0a.ack, m0a.err, m1a.ack, m1a.err};
  assign oresp[1] = {m0b.ack, m0b.err, m1b.ack, m1b.err};
  assign oresp[2] = {m0c.ack, m0c.err, m1c.ack, m1c.err};
  assign odr[0]   = {m0a.dat_r, m1a.dat_r};
  assign odr[1]   = {m0b.dat_r, m1b.dat_r};
  assign odr[2]   = {m0c.dat_r, m1c.dat_r};

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: who owns the slave (0 none, 1 m0, 2 m1), who was granted
  // last, and how many consecutive strobes the owner has left unanswered.
  int P [3] = '{0, 1, 0};
  int T [3] = '{16, 16, 0};
  int own   [3];
  int last  [3];
  int stall [3];

  function automatic bit wd_fire(int d);
    int x;
    if (own[d] == 0 || T[d] == 0) return 1'b0;
    x = own[d] - 1;
    return mdrv[x][6] && !sdrv[1] && !sdrv[0] && (stall[d] + 1 == T[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      own[d] = 0; last[d] = 1; stall[d] = 0;
    end
  endtask

  task automatic model_update(int d);
    logic [1:0] c;
    int x, w;
    c = {mdrv[1][7], mdrv[0][7]};
    if (own[d] == 0) begin
      stall[d] = 0;
      if (c != 2'b00) begin
        if (c == 2'b11) w = (P[d] != 0) ? 1 : 1 - last[d];
        else            w = c[1] ? 1 : 0;
        own[d]  = w + 1;
        last[d] = w;
      end
    end else begin
      x = own[d] - 1;
      if (!c[x]) begin
        stall[d] = 0;
        if (c[1-x]) begin
          own[d] = 2 - x; last[d] = 1 - x;
        end else begin
          own[d] = 0;
        end
      end else if (mdrv[x][6] && !sdrv[1] && !sdrv[0] && !wd_fire(d)) begin
        stall[d]++;
      end else begin
        stall[d] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [75:0] eb;
    logic [3:0]  er;
    logic        ack, err;
    int x;
    for (int d = 0; d < 3; d++) begin
      eb = '0; er = '0;
      ack = sdrv[1]; err = sdrv[0] | wd_fire(d);
      if (own[d] != 0) begin
        x  = own[d] - 1;
        eb = mdrv[x];
        er = (x == 0) ? {ack, err, 2'b00} : {2'b00, ack, err};
      end
      check($sformatf("dut%0d s_bus", d), 128'(obus[d]), 128'(eb));
      check($sformatf("dut%0d m_ack_err", d), 128'(oresp[d]), 128'(er));
      check($sformatf("dut%0d m_dat_r", d), 128'(odr[d]), 128'({sdrv[33:2], sdrv[33:2]}));
    end
  endtask

  // Watchdog observation counters for the held-strobe segment.
  bit          wd_track = 1'b0;
  int unsigned stbn = 0, errs_a = 0, errs_b = 0, errs_c = 0, first_a = 0;

  // Starts at posedge+1 with inputs already set; optionally releases reset
  // mid-cycle, checks at the falling edge, then advances the model.
  task automatic step(input bit rel_rst);
    if (rel_rst) begin
      #2; rst = 1'b1; #2;
    end else begin
      #4;
    end
    check_all();
    if (wd_track) begin
      if (sa.stb) stbn++;
      if (m0a.err) begin errs_a++; if (first_a == 0) first_a = stbn; end
      if (m0b.err) errs_b++;
      if (m0c.err) errs_c++;
    end
    @(posedge clk);
    if (rst) for (int d = 0; d < 3; d++) model_update(d);
    #1;
  endtask

  task automatic mid_reset();
    #3; rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs(input bit noack);
    logic cyc, stb;
    for (int m = 0; m < 2; m++) begin
      cyc = mdrv[m][7];
      if (cyc) begin
        if ($urandom_range(noack ? 63 : 5) == 0) cyc = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        cyc = 1'b1;
      end
      stb = cyc && ($urandom_range(3) != 0);
      mdrv[m] = {$urandom, $urandom, 4'($urandom), cyc, stb, 1'($urandom),
                 3'($urandom), 2'($urandom)};
    end
    sdrv = {$urandom, !noack && ($urandom_range(2) == 0),
                      !noack && ($urandom_range(15) == 0)};
  endtask

  initial begin
    bit noack;
    mdrv[0] = '0; mdrv[1] = '0; sdrv = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset state, then both masters tied from reset: m0 first, handover on
    // m0 release, round-robin back to m0.
    step(1'b0);
    mdrv[0] = {32'h8000_0000, 32'h1111_1111, 4'hf, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00};
    mdrv[1] = {32'h0000_1000, 32'h2222_2222, 4'h3, 1'b1, 1'b1, 1'b1, 3'b010, 2'b00};
    sdrv = {32'hCAFE_F00D, 1'b1, 1'b0};
    step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);
    mdrv[0][7] = 1'b0; mdrv[0][6] = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    mdrv[0][7] = 1'b1; mdrv[0][6] = 1'b1;
    mdrv[1][7] = 1'b0; mdrv[1][6] = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);

    // Reset in the middle of an m1 burst, then a tie right after release.
    mdrv[0][7] = 1'b0; mdrv[1][7] = 1'b1; mdrv[1][6] = 1'b1;
    step(1'b0); step(1'b0);
    mdrv[0][7] = 1'b1;
    mid_reset();
    step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Watchdog: m0 holds a strobe the slave never answers.
    mdrv[1] = '0;
    mdrv[0] = {32'h8000_0000, 32'h0, 4'hf, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00};
    sdrv = {32'h1234_5678, 1'b0, 1'b0};
    mid_reset();
    wd_track = 1'b1;
    step(1'b1);
    for (int i = 0; i < 1039; i++) step(1'b0);
    wd_track = 1'b0;
    check("wd stb cycles", 128'(stbn), 128'(1039));
    check("wd first err", 128'(first_a), 128'(16));
    check("wd errs T16", 128'(errs_a), 128'(1039 / 16));
    check("wd errs T16 p1", 128'(errs_b), 128'(1039 / 16));
    check("wd errs T0", 128'(errs_c), 128'(0));

    // Randomised traffic with stall bursts and occasional mid-cycle resets.
    noack = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) noack = !noack;
      rand_inputs(noack);
      if ($urandom_range(399) == 0 || i == 1500) begin
        mid_reset();
        step(1'b1);
      end else begin
        step(1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
